uart_tx_arbiter: RTL and testbench

- Shares the single UART transmit path among NUM_REQ independent requesters; the transmit path is the tx_req/tx_din/tx_ready port of the uart wrapper, with or without TX FIFO.
- Arbitration is round-robin at message granularity. A granted requester keeps the transmitter until it sends a byte flagged last, so multi-byte messages are never interleaved.
- An idle-timeout watchdog reclaims the grant from a requester that stalls mid-message.
- Sits between firmware/engine-side byte sources and the uart instance.

---
 rtl/uart_tx_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one UART transmit path among NUM_REQ byte sources. Ownership is
// granted round-robin per message: once granted, a requester keeps the
// transmitter until it hands over a byte flagged last, so messages are never
// interleaved. A watchdog reclaims the grant if the owner leaves req_valid
// low for IDLE_TIMEOUT consecutive cycles mid-message.
//
// Ports
//   clk          clock
//   rst          synchronous reset, active-high
//   req_valid    per-requester byte valid            [NUM_REQ]
//   req_data     per-requester byte, i at [i*WIDTH +: WIDTH]
//   req_last     per-requester end-of-message flag   [NUM_REQ]
//   req_ready    per-requester accept (owner only)   [NUM_REQ]
//   tx_req       byte request to the uart
//   tx_din       byte to the uart                    [WIDTH]
//   tx_ready     uart can take a byte
//   grant        one-hot current owner, zero when idle
//   busy         message in progress (ARB or XFER)
//   timeout_err  one-cycle pulse when the watchdog releases the owner
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int WIDTH        = 8,
    parameter int IDLE_TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]       req_last,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     tx_req,
    output logic [WIDTH-1:0]         tx_din,
    input  logic                     tx_ready,
    output logic [NUM_REQ-1:0]       grant,
    output logic                     busy,
    output logic                     timeout_err
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TW = $clog2(IDLE_TIMEOUT + 1);

    // The pointer names the last owner; the search starts one past it, so
    // resetting it to the top index makes requester 0 the first candidate.
    localparam logic [PW-1:0]      PTR_RST  = PW'(NUM_REQ - 1);
    localparam logic [TW-1:0]      TO_LAST  = TW'(IDLE_TIMEOUT - 1);
    localparam logic [TW-1:0]      TMR_ONE  = TW'(1);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARB  = 2'd1,
        XFER = 2'd2
    } state_t;

    state_t               state_r;
    logic [PW-1:0]        ptr_r;
    logic [PW-1:0]        gidx_r;
    logic [NUM_REQ-1:0]   grant_r;
    logic [NUM_REQ-1:0]   snap_r;
    logic                 busy_r;
    logic                 timeout_r;
    logic [TW-1:0]        timer_r;

    logic [PW-1:0]        arb_idx_s;
    logic                 arb_found_s;
    logic [PW-1:0]        cand_s;
    int                   cand_i;
    logic                 g_valid_s;
    logic                 g_last_s;
    logic [WIDTH-1:0]     g_data_s;
    logic                 xfer_s;

    // Round-robin search over the valid snapshot, starting at ptr+1 with wrap.
    always_comb begin
        arb_found_s = 1'b0;
        arb_idx_s   = ptr_r;
        cand_s      = ptr_r;
        cand_i      = 0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand_i = int'(ptr_r) + off;
            if (cand_i >= NUM_REQ) begin
                cand_i = cand_i - NUM_REQ;
            end else begin
                cand_i = cand_i;
            end
            cand_s = PW'(cand_i);
            if (!arb_found_s && snap_r[cand_s]) begin
                arb_found_s = 1'b1;
                arb_idx_s   = cand_s;
            end else begin
                arb_found_s = arb_found_s;
            end
        end
    end

    // One-hot mux of the owner's inputs; grant is zero outside XFER, so the
    // path is quiet in IDLE and ARB without extra gating.
    always_comb begin
        g_valid_s = 1'b0;
        g_last_s  = 1'b0;
        g_data_s  = {WIDTH{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            g_valid_s = g_valid_s | (grant_r[i] & req_valid[i]);
            g_last_s  = g_last_s  | (grant_r[i] & req_last[i]);
            g_data_s  = g_data_s  | (req_data[i*WIDTH +: WIDTH] & {WIDTH{grant_r[i]}});
        end
    end

    assign xfer_s      = g_valid_s & tx_ready;
    assign tx_req      = g_valid_s;
    assign tx_din      = g_data_s;
    assign req_ready   = grant_r & {NUM_REQ{tx_ready}};
    assign grant       = grant_r;
    assign busy        = busy_r;
    assign timeout_err = timeout_r;

    // Message-level arbitration FSM with idle watchdog and registered status.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            ptr_r     <= PTR_RST;
            gidx_r    <= {PW{1'b0}};
            grant_r   <= {NUM_REQ{1'b0}};
            snap_r    <= {NUM_REQ{1'b0}};
            busy_r    <= 1'b0;
            timeout_r <= 1'b0;
            timer_r   <= {TW{1'b0}};
        end else begin
            timeout_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    grant_r <= {NUM_REQ{1'b0}};
                    timer_r <= {TW{1'b0}};
                    if (|req_valid) begin
                        // Snapshot so a requester dropping valid during ARB
                        // is still granted; the watchdog then recovers.
                        snap_r  <= req_valid;
                        busy_r  <= 1'b1;
                        state_r <= ARB;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                ARB: begin
                    gidx_r  <= arb_idx_s;
                    grant_r <= ONE_HOT0 << arb_idx_s;
                    timer_r <= {TW{1'b0}};
                    busy_r  <= 1'b1;
                    state_r <= XFER;
                end
                XFER: begin
                    if (xfer_s && g_last_s) begin
                        ptr_r   <= gidx_r;
                        grant_r <= {NUM_REQ{1'b0}};
                        busy_r  <= 1'b0;
                        timer_r <= {TW{1'b0}};
                        state_r <= IDLE;
                    end else if (xfer_s) begin
                        timer_r <= {TW{1'b0}};
                    end else if (!g_valid_s) begin
                        if (timer_r == TO_LAST) begin
                            // This idle cycle is the IDLE_TIMEOUT-th in a row.
                            ptr_r     <= gidx_r;
                            grant_r   <= {NUM_REQ{1'b0}};
                            busy_r    <= 1'b0;
                            timer_r   <= {TW{1'b0}};
                            timeout_r <= 1'b1;
                            state_r   <= IDLE;
                        end else begin
                            timer_r <= timer_r + TMR_ONE;
                        end
                    end else begin
                        // Valid held but uart stalled: never a timeout.
                        timer_r <= timer_r;
                    end
                end
                default: begin
                    grant_r <= {NUM_REQ{1'b0}};
                    busy_r  <= 1'b0;
                    timer_r <= {TW{1'b0}};
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Directed bench for uart_tx_arbiter (NUM_REQ=4, WIDTH=8, IDLE_TIMEOUT=10).
// Each requester is a small byte source: it sends nb bytes, base+0 .. base+nb-1,
// flagging last every ml bytes. Transfers are logged as {owner index, byte}
// and compared with hand-written expected sequences.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int TO = 10;

    logic             clk;
    logic             rst;
    logic [N-1:0]     req_valid;
    logic [N*W-1:0]   req_data;
    logic [N-1:0]     req_last;
    logic [N-1:0]     req_ready;
    logic             tx_req;
    logic [W-1:0]     tx_din;
    logic             tx_ready;
    logic [N-1:0]     grant;
    logic             busy;
    logic             timeout_err;

    uart_tx_arbiter #(
        .NUM_REQ      (N),
        .WIDTH        (W),
        .IDLE_TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .tx_req      (tx_req),
        .tx_din      (tx_din),
        .tx_ready    (tx_ready),
        .grant       (grant),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // source model state
    bit          en   [N];
    int          bc   [N];
    int          nb   [N];
    int          ml   [N];
    logic [7:0]  base [N];
    logic [N-1:0] hs;
    int          cyc_no;
    logic [11:0] log_q [$];
    int          log_t [$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_sources();
        for (int i = 0; i < N; i++) begin
            req_valid[i]         = en[i] && (bc[i] < nb[i]);
            req_data[i*W +: W]   = base[i] + 8'(bc[i]);
            req_last[i]          = (((bc[i] + 1) % ml[i]) == 0);
        end
    endtask

    task automatic setup(input int i, input bit e, input int n, input int m, input logic [7:0] b);
        en[i]   = e;
        nb[i]   = n;
        ml[i]   = m;
        base[i] = b;
        bc[i]   = 0;
    endtask

    task automatic clear_all();
        for (int i = 0; i < N; i++) setup(i, 1'b0, 0, 1, 8'h00);
        drive_sources();
        log_q.delete();
        log_t.delete();
    endtask

    // Sample on the falling edge: record handshakes and log transfers.
    task automatic sample();
        int gi;
        @(negedge clk);
        hs = req_valid & req_ready;
        if (tx_req && tx_ready) begin
            gi = 0;
            for (int i = 0; i < N; i++) if (grant[i]) gi = i;
            log_q.push_back({gi[3:0], tx_din});
            log_t.push_back(cyc_no);
        end
    endtask

    // Step past the rising edge and let accepted sources move on.
    task automatic advance();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) if (hs[i]) bc[i]++;
        cyc_no++;
        drive_sources();
    endtask

    task automatic run_until(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (log_q.size() < n && k < budget) begin
            sample();
            advance();
            k++;
        end
        check_eq(tag, 32'(log_q.size()), 32'(n));
    endtask

    task automatic check_log(input string tag, input int idx, input logic [11:0] exp);
        logic [31:0] obs;
        obs = (idx < log_q.size()) ? 32'(log_q[idx]) : 32'hDEAD_BEEF;
        check_eq(tag, obs, 32'(exp));
    endtask

    // Leaves the bench at the sampled falling edge of the wanted transfer.
    task automatic wait_xfer(input logic [N-1:0] who, input string tag);
        bit found;
        int k;
        found = 1'b0;
        k = 0;
        while (!found && k < 30) begin
            sample();
            if (tx_req && tx_ready && grant == who) found = 1'b1;
            else begin
                advance();
                k++;
            end
        end
        check_eq(tag, 32'(found), 32'h1);
    endtask

    logic [11:0] rr_exp [10];
    logic [11:0] to_exp [5];
    int          to_seen;

    initial begin
        rr_exp = '{12'h000, 12'h001, 12'h110, 12'h111, 12'h220,
                   12'h221, 12'h330, 12'h331, 12'h002, 12'h003};
        to_exp = '{12'h330, 12'h000, 12'h001, 12'h110, 12'h331};
        cyc_no   = 0;
        hs       = '0;
        rst      = 1'b1;
        tx_ready = 1'b1;
        clear_all();

        // ---------------- reset state ----------------
        advance();
        advance();
        sample();
        check_eq("rst_grant", 32'(grant), 32'h0);
        check_eq("rst_busy", 32'(busy), 32'h0);
        check_eq("rst_timeout", 32'(timeout_err), 32'h0);
        check_eq("rst_tx_req", 32'(tx_req), 32'h0);
        check_eq("rst_req_ready", 32'(req_ready), 32'h0);
        advance();
        rst = 1'b0;

        // ---------------- single 3-byte message from req 2 ----------------
        setup(2, 1'b1, 3, 3, 8'h41);
        drive_sources();
        sample();
        check_eq("s_idle_busy", 32'(busy), 32'h0);
        check_eq("s_idle_tx_req", 32'(tx_req), 32'h0);
        advance();
        sample();
        check_eq("s_arb_busy", 32'(busy), 32'h1);
        check_eq("s_arb_grant", 32'(grant), 32'h0);
        check_eq("s_arb_tx_req", 32'(tx_req), 32'h0);
        advance();
        sample();
        check_eq("s_grant", 32'(grant), 32'h4);
        check_eq("s_tx_req", 32'(tx_req), 32'h1);
        check_eq("s_byte0", 32'(tx_din), 32'h41);
        check_eq("s_req_ready", 32'(req_ready), 32'h4);
        advance();
        sample();
        check_eq("s_byte1", 32'(tx_din), 32'h42);
        advance();
        sample();
        check_eq("s_byte2", 32'(tx_din), 32'h43);
        check_eq("s_busy_last", 32'(busy), 32'h1);
        advance();
        sample();
        check_eq("s_busy_after", 32'(busy), 32'h0);
        check_eq("s_grant_after", 32'(grant), 32'h0);
        check_eq("s_tx_req_after", 32'(tx_req), 32'h0);
        check_eq("s_count", 32'(log_q.size()), 32'h3);
        advance();

        // ---------------- round-robin, all requesters busy ----------------
        rst = 1'b1;
        clear_all();
        sample();
        advance();
        rst = 1'b0;
        setup(0, 1'b1, 4, 2, 8'h00);
        setup(1, 1'b1, 2, 2, 8'h10);
        setup(2, 1'b1, 2, 2, 8'h20);
        setup(3, 1'b1, 2, 2, 8'h30);
        drive_sources();
        run_until(10, 80, "rr_count");
        for (int i = 0; i < 10; i++) check_log("rr_order", i, rr_exp[i]);
        if (log_t.size() >= 3) begin
            check_eq("rr_in_msg_gap", 32'(log_t[1] - log_t[0]), 32'h1);
            check_eq("rr_msg_gap", 32'(log_t[2] - log_t[1]), 32'h3);
        end
        sample();
        advance();

        // ---------------- backpressure on a 3-byte message from req 1 ----------------
        clear_all();
        setup(1, 1'b1, 3, 3, 8'hA0);
        drive_sources();
        tx_ready = 1'b1;
        sample();
        advance();
        sample();
        advance();
        sample();
        check_eq("bp_grant", 32'(grant), 32'h2);
        check_eq("bp_byte0", 32'(tx_din), 32'hA0);
        check_eq("bp_ready_on", 32'(req_ready), 32'h2);
        advance();
        tx_ready = 1'b0;
        sample();
        check_eq("bp_ready_off", 32'(req_ready), 32'h0);
        check_eq("bp_tx_req_held", 32'(tx_req), 32'h1);
        check_eq("bp_byte1_held", 32'(tx_din), 32'hA1);
        advance();
        sample();
        advance();
        tx_ready = 1'b1;
        sample();
        check_eq("bp_byte1", 32'(tx_din), 32'hA1);
        advance();
        tx_ready = 1'b0;
        to_seen = 0;
        repeat (300) begin
            sample();
            if (timeout_err) to_seen++;
            advance();
        end
        check_eq("bp_no_timeout", 32'(to_seen), 32'h0);
        sample();
        check_eq("bp_grant_kept", 32'(grant), 32'h2);
        advance();
        tx_ready = 1'b1;
        sample();
        check_eq("bp_byte2", 32'(tx_din), 32'hA2);
        advance();
        sample();
        check_eq("bp_busy_after", 32'(busy), 32'h0);
        advance();
        check_eq("bp_count", 32'(log_q.size()), 32'h3);
        check_log("bp_log0", 0, 12'h1A0);
        check_log("bp_log1", 1, 12'h1A1);
        check_log("bp_log2", 2, 12'h1A2);

        // ---------------- idle timeout on req 3, then fairness ----------------
        clear_all();
        setup(3, 1'b1, 1, 2, 8'h30);
        drive_sources();
        wait_xfer(4'h8, "to_first_xfer");
        check_eq("to_byte0", 32'(tx_din), 32'h30);
        advance();
        setup(0, 1'b1, 2, 2, 8'h00);
        setup(1, 1'b1, 1, 1, 8'h10);
        drive_sources();
        for (int j = 1; j <= TO; j++) begin
            sample();
            check_eq("to_early", 32'(timeout_err), 32'h0);
            check_eq("to_grant_held", 32'(grant), 32'h8);
            advance();
        end
        sample();
        check_eq("to_pulse", 32'(timeout_err), 32'h1);
        check_eq("to_grant_clr", 32'(grant), 32'h0);
        check_eq("to_busy_clr", 32'(busy), 32'h0);
        advance();
        nb[3] = 2;
        drive_sources();
        sample();
        check_eq("to_pulse_end", 32'(timeout_err), 32'h0);
        advance();
        sample();
        check_eq("to_next_grant", 32'(grant), 32'h1);
        advance();
        run_until(5, 40, "to_count");
        for (int i = 0; i < 5; i++) check_log("to_order", i, to_exp[i]);
        sample();
        advance();

        // ---------------- reset in the middle of a message from req 1 ----------------
        clear_all();
        setup(0, 1'b1, 1, 1, 8'h00);
        setup(1, 1'b1, 4, 4, 8'h10);
        drive_sources();
        wait_xfer(4'h2, "rs_mid_msg");
        advance();
        setup(0, 1'b1, 1, 1, 8'h00);
        drive_sources();
        rst = 1'b1;
        sample();
        advance();
        rst = 1'b0;
        sample();
        check_eq("rs_grant", 32'(grant), 32'h0);
        check_eq("rs_tx_req", 32'(tx_req), 32'h0);
        check_eq("rs_busy", 32'(busy), 32'h0);
        check_eq("rs_req_ready", 32'(req_ready), 32'h0);
        advance();
        sample();
        check_eq("rs_arb_busy", 32'(busy), 32'h1);
        advance();
        sample();
        check_eq("rs_first_grant", 32'(grant), 32'h1);
        advance();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "time limit reached");
    end

endmodule
